ldtu_decoder: RTL
=================

Name: ldtu_decoder

Overview:
- Receive-side counterpart of the LiTe-DTU encoder. Accepts the 32-bit encoded words and their Load strobe, in either normal or fallback mode.
- Reconstructs the 13-bit sample stream at one sample per cycle. Flags each sample as baseline, orbit (BC0) or header.
- Used in the back-end emulator and the verification environment to close the encode/decode loop.
- Buffers words in a small FIFO because word arrival is bursty relative to sample output.

Parameters:
- WDEPTH, 4, word FIFO depth; power of two, >=2.
- Nbits_12, 12, MSB index of a sample (sample width 13).
- Nbits_32, 32, encoded word width.
- sync, 13'b0101010101010, orbit marker field.
- header_synch, 13'b1111000001111, header marker field.

Ports:
- CLK  input  1  LiTe-DTU clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- fallback  input  1  mode qualifier, sampled together with each accepted word.
- DATA_32  input  32  encoded word.
- Load  input  1  DATA_32 valid this cycle.
- DATA_out  output  13  decoded sample; a 6-bit baseline is zero-extended.
- DValid  output  1  DATA_out valid this cycle.
- Baseline  output  1  sample came from a baseline word.
- Orbit_flag  output  1  sample came from a sign2+sync word.
- Header_flag  output  1  sample came from a sign2+header word.
- CodeError  output  1  one-cycle pulse: popped word undecodable, discarded.
- ParityError  output  1  one-cycle pulse: fallback word parity mismatch.
- Overflow  output  1  sticky: a word was dropped because the FIFO was full; cleared by reset only.

Behaviour:
- Reset (async, active-high): FIFO empty, unpacker empty, every output 0. Asserting reset mid-word abandons that word.
- Acceptance: a word is accepted when Load=1 and the FIFO is not full, or is full but popped in the same cycle. {fallback, DATA_32} is written as one 33-bit entry. The mode is therefore fixed per word; a fallback toggle never re-interprets queued words.
- Load with FIFO full and no pop: word dropped, Overflow <= 1.
- Output scheduling: outputs are registered. At each edge:
  - If the unpacker holds remaining samples, emit the next one.
  - Else, if the FIFO is non-empty, pop a word and emit its first sample on that same edge; the rest are loaded into the unpacker. There is no bubble between words.
  - Else DValid=0 and the flags are 0.
- Latency: Load at edge k into an empty, idle decoder gives the first sample valid after edge k+1.
- Normal-mode decode (samples emitted lowest field first):
  - [31:30]=01 (bas1): five 6-bit samples [5:0], [11:6], [17:12], [23:18], [29:24]. Baseline=1.
  - [31:30]=10 (bas2): n=[29:24], valid values 1..4. Emit n samples from [5:0] upward in 6-bit steps. Filler bits are ignored. Baseline=1. n outside 1..4 gives CodeError.
  - [31:26]=001010 (sign1): emit [12:0] then [25:13]. Baseline=0.
  - [31:26]=001011 (sign2): emit [12:0]. [25:13]==sync sets Orbit_flag; ==header_synch sets Header_flag; any other value gives CodeError.
  - 32'hF0000000 (idle/initial): ignored; pop cycle has DValid=0, no error.
  - Anything else: CodeError pulse on the pop edge, DValid=0.
- Fallback-mode decode:
  - 32'h0 is ignored.
  - Otherwise [31:28] must be 1111, else CodeError.
  - Emit [12:0] (odd) then [25:13] (even). Baseline=0.
  - Parity check: bit26 must equal ~^[12:0] and bit27 must equal ~^[25:13]. A mismatch pulses ParityError on the pop edge; samples are still emitted.
- Flags are valid only when DValid=1.
- CodeError and ParityError are pulses coincident with the pop edge of the offending word.
- A simultaneous push and pop at full or empty is legal. Pointers wrap modulo WDEPTH.

Test Plan:
- bas1: Load 0x45103081 once, idle otherwise -> DATA_out 1,2,3,4,5 on five consecutive cycles starting one cycle after Load; Baseline=1 throughout.
- bas2 then sign1 back-to-back: Load 0x82000247, next cycle Load 0x2A8AC123 -> 7, 9 (Baseline=1), then 0x0123, 0x1456 (Baseline=0), with no gap.
- Markers: Load 0x2D554042 -> single sample 0x0042 with Orbit_flag=1. Load 0x2FC1E042 -> 0x0042 with Header_flag=1. Load 0x2C000042 -> CodeError pulse, no DValid.
- Idle and illegal words: Load 0xF0000000 -> nothing emitted, no error. Load 0xC0000000 -> CodeError. Load 0x81000000 (n=1, filler 0) -> sample 0 with Baseline=1.
- Overflow: Load 0x45103081 on 12 consecutive cycles -> Overflow rises and stays 1. Every emitted group is a complete 1..5. A mid-burst reset clears Overflow, DValid and the FIFO immediately.
- Fallback: fallback=1, Load 0xF4002003 -> 0x0003 then 0x0001, no ParityError. Load 0xF0002003 -> same samples plus a ParityError pulse. Toggling fallback while words are queued leaves their decode unchanged.

Source files
------------

// File: rtl/ldtu_decoder.sv
// LiTe-DTU receive-side decoder: buffers encoded words in a small FIFO
// and unpacks them into a 13-bit sample stream, one sample per cycle.
module ldtu_decoder #(
  parameter int          WDEPTH       = 4,
  parameter int          Nbits_12     = 12,
  parameter int          Nbits_32     = 32,
  parameter logic [12:0] sync         = 13'b0101010101010,
  parameter logic [12:0] header_synch = 13'b1111000001111
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                fallback,
  input  logic [Nbits_32-1:0] DATA_32,
  input  logic                Load,
  output logic [Nbits_12:0]   DATA_out,
  output logic                DValid,
  output logic                Baseline,
  output logic                Orbit_flag,
  output logic                Header_flag,
  output logic                CodeError,
  output logic                ParityError,
  output logic                Overflow
);

  localparam int AW = $clog2(WDEPTH);
  localparam int SW = Nbits_12 + 1;

  logic [Nbits_32:0]      mem_q [WDEPTH];
  logic [AW:0]            wr_q, wr_d, rd_q, rd_d;
  logic                   full, empty, pop, push;

  logic [3:0][SW-1:0]     sh_q, sh_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   ub_q, ub_d;

  logic [SW-1:0]          data_q, data_d;
  logic                   dv_q, dv_d, base_q, base_d;
  logic                   orb_q, orb_d, hdr_q, hdr_d;
  logic                   ce_q, ce_d, pe_q, pe_d, ovf_q, ovf_d;

  logic [Nbits_32:0]      entry;
  logic                   fb;
  logic [31:0]            w;
  logic [2:0]             dec_n;
  logic [4:0][SW-1:0]     dec_s;
  logic                   dec_base, dec_orb, dec_hdr, dec_ce, dec_pe;

  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);
  assign pop   = (cnt_q == 3'd0) && !empty;
  assign push  = Load && (!full || pop);

  assign entry = mem_q[rd_q[AW-1:0]];
  assign fb    = entry[Nbits_32];
  assign w     = entry[31:0];

  always_comb begin
    dec_n    = 3'd0;
    dec_s    = '0;
    dec_base = 1'b0;
    dec_orb  = 1'b0;
    dec_hdr  = 1'b0;
    dec_ce   = 1'b0;
    dec_pe   = 1'b0;
    if (fb) begin
      if (w == 32'h0) begin
        dec_n = 3'd0;
      end else if (w[31:28] != 4'hF) begin
        dec_ce = 1'b1;
      end else begin
        dec_n    = 3'd2;
        dec_s[0] = SW'(w[12:0]);
        dec_s[1] = SW'(w[25:13]);
        // Odd parity: each stored bit is the XNOR of its 13-bit half
        dec_pe   = (w[26] != ~^w[12:0]) ||
                   (w[27] != ~^w[25:13]);
      end
    end else begin
      unique case (1'b1)
        (w[31:30] == 2'b01): begin
          dec_n    = 3'd5;
          dec_base = 1'b1;
          for (int i = 0; i < 5; i++)
            dec_s[i] = SW'(w[6*i +: 6]);
        end
        (w[31:30] == 2'b10): begin
          if (w[29:24] >= 6'd1 && w[29:24] <= 6'd4) begin
            dec_n    = w[26:24];
            dec_base = 1'b1;
            for (int i = 0; i < 4; i++)
              dec_s[i] = SW'(w[6*i +: 6]);
          end else begin
            dec_ce = 1'b1;
          end
        end
        (w[31:26] == 6'b001010): begin
          dec_n    = 3'd2;
          dec_s[0] = SW'(w[12:0]);
          dec_s[1] = SW'(w[25:13]);
        end
        (w[31:26] == 6'b001011): begin
          if (w[25:13] == sync) begin
            dec_n   = 3'd1;
            dec_orb = 1'b1;
          end else if (w[25:13] == header_synch) begin
            dec_n   = 3'd1;
            dec_hdr = 1'b1;
          end else begin
            dec_ce = 1'b1;
          end
          dec_s[0] = SW'(w[12:0]);
        end
        (w == 32'hF000_0000): begin
          dec_n = 3'd0;
        end
        default: dec_ce = 1'b1;
      endcase
    end
  end

  always_comb begin
    wr_d   = wr_q + (AW+1)'(push);
    rd_d   = rd_q + (AW+1)'(pop);
    ovf_d  = ovf_q | (Load && full && !pop);
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    ub_d   = ub_q;
    dv_d   = 1'b0;
    data_d = '0;
    base_d = 1'b0;
    orb_d  = 1'b0;
    hdr_d  = 1'b0;
    ce_d   = 1'b0;
    pe_d   = 1'b0;
    if (cnt_q != 3'd0) begin
      dv_d   = 1'b1;
      data_d = sh_q[0];
      base_d = ub_q;
      sh_d   = {{SW{1'b0}}, sh_q[3:1]};
      cnt_d  = cnt_q - 3'd1;
    end else if (pop) begin
      ce_d = dec_ce;
      pe_d = dec_pe;
      // First sample leaves on the pop edge; the rest wait in sh_q
      if (dec_n != 3'd0) begin
        dv_d   = 1'b1;
        data_d = dec_s[0];
        base_d = dec_base;
        orb_d  = dec_orb;
        hdr_d  = dec_hdr;
        sh_d   = dec_s[4:1];
        cnt_d  = dec_n - 3'd1;
        ub_d   = dec_base;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {fallback, DATA_32};
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      ub_q   <= 1'b0;
      dv_q   <= 1'b0;
      data_q <= '0;
      base_q <= 1'b0;
      orb_q  <= 1'b0;
      hdr_q  <= 1'b0;
      ce_q   <= 1'b0;
      pe_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      ub_q   <= ub_d;
      dv_q   <= dv_d;
      data_q <= data_d;
      base_q <= base_d;
      orb_q  <= orb_d;
      hdr_q  <= hdr_d;
      ce_q   <= ce_d;
      pe_q   <= pe_d;
      ovf_q  <= ovf_d;
    end
  end

  assign DATA_out    = data_q;
  assign DValid      = dv_q;
  assign Baseline    = base_q;
  assign Orbit_flag  = orb_q;
  assign Header_flag = hdr_q;
  assign CodeError   = ce_q;
  assign ParityError = pe_q;
  assign Overflow    = ovf_q;

endmodule
